// File: rtl/dma_pkg.sv
// Shared definitions for the chip-bus DMA slot scheduler and its debug monitor:
// owner encoding, grant bit positions and the default fixed-slot positions.
package dma_pkg;

    localparam int unsigned HPOS_W  = 9;
    localparam int unsigned SLOT_W  = 8;
    localparam int unsigned OWNER_W = 4;
    localparam int unsigned GRANT_W = 8;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned WAIT_W  = 2;

    // Highest CCK index on a normal line; anything above is a free slot.
    localparam logic [SLOT_W-1:0] LAST_CCK = 8'd226;

    typedef enum logic [OWNER_W-1:0] {
        OWN_IDLE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_SPR  = 4'd4,
        OWN_BPL  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_e;

    // Grant bit indices: {cpu,blt,cop,bpl,spr,aud,dsk,ref}.
    localparam int unsigned G_REF = 0;
    localparam int unsigned G_DSK = 1;
    localparam int unsigned G_AUD = 2;
    localparam int unsigned G_SPR = 3;
    localparam int unsigned G_BPL = 4;
    localparam int unsigned G_COP = 5;
    localparam int unsigned G_BLT = 6;
    localparam int unsigned G_CPU = 7;

    // Default fixed-slot positions (all on odd CCKs, two CCKs apart).
    localparam logic [SLOT_W-1:0] REF_FIRST_DEF = 8'h01;
    localparam logic [SLOT_W-1:0] DSK_FIRST_DEF = 8'h09;
    localparam logic [SLOT_W-1:0] AUD_FIRST_DEF = 8'h0F;
    localparam logic [SLOT_W-1:0] SPR_FIRST_DEF = 8'h17;
    localparam int unsigned REF_SLOTS = 4;
    localparam int unsigned DSK_SLOTS = 3;
    localparam int unsigned AUD_SLOTS = 4;
    localparam int unsigned SPR_SLOTS = 16;

    // Owner code to one-hot grant; IDLE maps to no grant.
    function automatic logic [GRANT_W-1:0] owner_to_grant(input owner_e o);
        logic [GRANT_W-1:0] g;
        g = '0;
        if (o != OWN_IDLE) begin
            g = GRANT_W'(1) << (OWNER_W'(o) - OWNER_W'(1));
        end
        return g;
    endfunction

endpackage

// File: rtl/dma_slot_scheduler_if.sv
// Beam position, DMACON enables, engine requests and the registered slot grant.
// master: beam/request side (drives inputs); slave: the scheduler.
interface dma_slot_scheduler_if;
    import dma_pkg::*;

    logic                cck;
    logic [HPOS_W-1:0]   hpos;
    logic                vbl;
    logic                vblend;
    logic                dmaen;
    logic                dsken;
    logic                spren;
    logic                copen;
    logic                blten;
    logic                bplen;
    logic [3:0]          auden;
    logic                bltpri;
    logic                req_dsk;
    logic [3:0]          req_aud;
    logic                req_bpl;
    logic                req_cop;
    logic                req_blt;
    logic                req_cpu;
    logic [GRANT_W-1:0]  grant;
    owner_e              owner;
    logic [CH_W-1:0]     slot_ch;
    logic                cpu_ok;

    modport master (
        output cck, hpos, vbl, vblend,
        output dmaen, dsken, spren, copen, blten, bplen, auden, bltpri,
        output req_dsk, req_aud, req_bpl, req_cop, req_blt, req_cpu,
        input  grant, owner, slot_ch, cpu_ok
    );

    modport slave (
        input  cck, hpos, vbl, vblend,
        input  dmaen, dsken, spren, copen, blten, bplen, auden, bltpri,
        input  req_dsk, req_aud, req_bpl, req_cop, req_blt, req_cpu,
        output grant, owner, slot_ch, cpu_ok
    );

endinterface

// File: rtl/dma_slot_decode.sv
// Combinational fixed-slot decode: CCK index -> fixed owner and sub-channel.
// Ports: slot_idx (hpos[8:1]); fix_owner_c (REF/DSK/AUD/SPR or IDLE);
// fix_ch_c (audio 0..3, or sprite number in [3:1] with data/pos word in [0]).
module dma_slot_decode
    import dma_pkg::*;
#(
    parameter logic [SLOT_W-1:0] REF_FIRST = REF_FIRST_DEF,
    parameter logic [SLOT_W-1:0] DSK_FIRST = DSK_FIRST_DEF,
    parameter logic [SLOT_W-1:0] AUD_FIRST = AUD_FIRST_DEF,
    parameter logic [SLOT_W-1:0] SPR_FIRST = SPR_FIRST_DEF
) (
    input  logic [SLOT_W-1:0] slot_idx,
    output owner_e            fix_owner_c,
    output logic [CH_W-1:0]   fix_ch_c
);

    // Fixed slots live on odd CCKs only, spaced two CCKs apart.
    always_comb begin
        fix_owner_c = OWN_IDLE;
        fix_ch_c    = '0;
        if (slot_idx[0] && (slot_idx <= LAST_CCK)) begin
            if ((slot_idx >= REF_FIRST) && (slot_idx < REF_FIRST + SLOT_W'(2 * REF_SLOTS))) begin
                fix_owner_c = OWN_REF;
            end else if ((slot_idx >= DSK_FIRST) && (slot_idx < DSK_FIRST + SLOT_W'(2 * DSK_SLOTS))) begin
                fix_owner_c = OWN_DSK;
            end else if ((slot_idx >= AUD_FIRST) && (slot_idx < AUD_FIRST + SLOT_W'(2 * AUD_SLOTS))) begin
                fix_owner_c = OWN_AUD;
                fix_ch_c    = CH_W'((slot_idx - AUD_FIRST) >> 1);
            end else if ((slot_idx >= SPR_FIRST) && (slot_idx < SPR_FIRST + SLOT_W'(2 * SPR_SLOTS))) begin
                // Offset/2 = 2*sprite + word, which is exactly the slot_ch layout.
                fix_owner_c = OWN_SPR;
                fix_ch_c    = CH_W'((slot_idx - SPR_FIRST) >> 1);
            end
        end
    end

endmodule

// File: rtl/dma_slot_scheduler.sv
// Chip-bus DMA slot scheduler: grants each CCK slot to exactly one owner.
// Ports: clk (2 clk per CCK), _reset (async, active low), bus (slave modport:
// beam position, enables, requests in; grant/owner/slot_ch/cpu_ok out, all
// registered and updated on the clk edge where cck==0).
module dma_slot_scheduler
    import dma_pkg::*;
#(
    parameter logic [SLOT_W-1:0] REF_FIRST       = REF_FIRST_DEF,
    parameter logic [SLOT_W-1:0] DSK_FIRST       = DSK_FIRST_DEF,
    parameter logic [SLOT_W-1:0] AUD_FIRST       = AUD_FIRST_DEF,
    parameter logic [SLOT_W-1:0] SPR_FIRST       = SPR_FIRST_DEF,
    parameter int unsigned       BLT_NASTY_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  _reset,
    dma_slot_scheduler_if.slave   bus
);

    owner_e              fix_owner_c;
    logic [CH_W-1:0]     fix_ch_c;
    logic                fix_ok_c;
    owner_e              win_c;
    logic [CH_W-1:0]     ch_c;
    logic                nasty_c;
    logic [WAIT_W-1:0]   wait_nxt_c;

    owner_e              owner_q;
    logic [GRANT_W-1:0]  grant_q;
    logic [CH_W-1:0]     ch_q;
    logic                cpu_ok_q;
    logic [WAIT_W-1:0]   blt_wait;

    // Slot parity is carried by hpos[8:1]; the clk half-phase bit is not needed.
    logic unused_hpos0;
    assign unused_hpos0 = bus.hpos[0];

    dma_slot_decode #(
        .REF_FIRST (REF_FIRST),
        .DSK_FIRST (DSK_FIRST),
        .AUD_FIRST (AUD_FIRST),
        .SPR_FIRST (SPR_FIRST)
    ) u_decode (
        .slot_idx    (bus.hpos[HPOS_W-1:1]),
        .fix_owner_c (fix_owner_c),
        .fix_ch_c    (fix_ch_c)
    );

    // Is the fixed owner of this slot actually taking it?
    always_comb begin
        fix_ok_c = 1'b0;
        unique case (fix_owner_c)
            OWN_REF: fix_ok_c = 1'b1;
            OWN_DSK: fix_ok_c = bus.dmaen & bus.dsken & bus.req_dsk;
            OWN_AUD: fix_ok_c = bus.dmaen & bus.auden[fix_ch_c[1:0]] & bus.req_aud[fix_ch_c[1:0]];
            OWN_SPR: fix_ok_c = bus.dmaen & bus.spren & (~bus.vbl | bus.vblend);
            default: fix_ok_c = 1'b0;
        endcase
    end

    // Priority resolver and blitter-nasty guard.
    always_comb begin
        win_c      = OWN_IDLE;
        ch_c       = '0;
        nasty_c    = (blt_wait == WAIT_W'(BLT_NASTY_LIMIT)) & bus.req_cpu & ~bus.bltpri;
        wait_nxt_c = blt_wait;

        if (fix_ok_c) begin
            win_c = fix_owner_c;
            ch_c  = fix_ch_c;
        end else if (bus.dmaen & bus.bplen & bus.req_bpl & ~bus.vbl) begin
            win_c = OWN_BPL;
        end else if (bus.dmaen & bus.copen & bus.req_cop & ~bus.hpos[1]) begin
            win_c = OWN_COP;
        end else if (bus.dmaen & bus.blten & bus.req_blt) begin
            win_c = nasty_c ? OWN_CPU : OWN_BLT;
        end else if (bus.req_cpu) begin
            win_c = OWN_CPU;
        end

        // Count blitter wins the CPU had to sit through; hold on other owners.
        if (bus.bltpri | ~bus.req_cpu | (win_c == OWN_CPU)) begin
            wait_nxt_c = '0;
        end else if ((win_c == OWN_BLT) && (blt_wait != '1)) begin
            wait_nxt_c = blt_wait + WAIT_W'(1);
        end
    end

    // Decision registered once per CCK, on the cck==0 edge.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            owner_q  <= OWN_IDLE;
            grant_q  <= '0;
            ch_q     <= '0;
            cpu_ok_q <= 1'b0;
            blt_wait <= '0;
        end else if (!bus.cck) begin
            owner_q  <= win_c;
            grant_q  <= owner_to_grant(win_c);
            ch_q     <= ch_c;
            cpu_ok_q <= (win_c == OWN_CPU);
            blt_wait <= wait_nxt_c;
        end
    end

    assign bus.owner   = owner_q;
    assign bus.grant   = grant_q;
    assign bus.slot_ch = ch_q;
    assign bus.cpu_ok  = cpu_ok_q;

endmodule

// File: tb/tb_dma_slot_scheduler.sv
// Self-checking bench for dma_slot_scheduler: directed slots from the test
// plan followed by randomized slots checked against a rule-level model.
module tb_dma_slot_scheduler;

    localparam int IDLE = 0;
    localparam int REF  = 1;
    localparam int DSK  = 2;
    localparam int AUD  = 3;
    localparam int SPR  = 4;
    localparam int BPL  = 5;
    localparam int COP  = 6;
    localparam int BLT  = 7;
    localparam int CPU  = 8;

    logic clk = 1'b0;
    logic _reset;

    always #5 clk = ~clk;

    dma_slot_scheduler_if bus ();

    dma_slot_scheduler dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int streak   = 0;   // blitter wins in a row while the CPU waited
    int exp_own  = 0;
    int exp_ch   = 0;
    int seq_exp [8];
    int s_cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Owner of a slot, derived from the slot table and priority rules.
    task automatic model_slot(input int s);
        int own;
        int ch;
        int n;
        own = IDLE;
        ch  = 0;
        if ((s % 2 == 1) && (s <= 226)) begin
            if (s >= 1 && s <= 7) begin
                own = REF;
            end else if (s >= 9 && s <= 13) begin
                if (bus.dmaen && bus.dsken && bus.req_dsk) own = DSK;
            end else if (s >= 15 && s <= 21) begin
                n = (s - 15) / 2;
                if (bus.dmaen && bus.auden[n] && bus.req_aud[n]) begin
                    own = AUD;
                    ch  = n;
                end
            end else if (s >= 23 && s <= 53) begin
                if (bus.dmaen && bus.spren && (!bus.vbl || bus.vblend)) begin
                    own = SPR;
                    ch  = ((s - 23) / 4) * 2 + ((s - 23) / 2) % 2;
                end
            end
        end
        if (own == IDLE) begin
            if (bus.dmaen && bus.bplen && bus.req_bpl && !bus.vbl) own = BPL;
            else if (bus.dmaen && bus.copen && bus.req_cop && (s % 2 == 0)) own = COP;
            else if (bus.dmaen && bus.blten && bus.req_blt)
                own = (bus.req_cpu && !bus.bltpri && streak >= 3) ? CPU : BLT;
            else if (bus.req_cpu) own = CPU;
        end
        if (bus.bltpri || !bus.req_cpu || own == CPU) streak = 0;
        else if (own == BLT) streak++;
        exp_own = own;
        exp_ch  = ch;
    endtask

    function automatic int grant_of(input int own);
        return (own == IDLE) ? 0 : (1 << (own - 1));
    endfunction

    task automatic rand_inputs();
        bus.vbl     = ($urandom_range(0, 3) == 0);
        bus.vblend  = ($urandom_range(0, 3) == 0);
        bus.dmaen   = ($urandom_range(0, 9) != 0);
        bus.dsken   = 1'($urandom);
        bus.spren   = 1'($urandom);
        bus.copen   = 1'($urandom);
        bus.blten   = ($urandom_range(0, 3) != 0);
        bus.bplen   = 1'($urandom);
        bus.auden   = 4'($urandom);
        bus.bltpri  = ($urandom_range(0, 3) == 0);
        bus.req_dsk = 1'($urandom);
        bus.req_aud = 4'($urandom);
        bus.req_bpl = ($urandom_range(0, 3) == 0);
        bus.req_cop = ($urandom_range(0, 2) == 0);
        bus.req_blt = ($urandom_range(0, 3) != 0);
        bus.req_cpu = ($urandom_range(0, 3) != 0);
    endtask

    // One CCK: decide edge, full output check, then hold check on the cck==1 edge.
    task automatic run_slot(input int s, input string tag, input bit jitter);
        int hold_own;
        @(negedge clk);
        bus.cck  = 1'b0;
        bus.hpos = 9'(s * 2);
        model_slot(s);
        hold_own = exp_own;
        @(posedge clk);
        #1;
        check($sformatf("%s_own", tag), 32'(bus.owner), exp_own);
        check($sformatf("%s_gnt", tag), 32'(bus.grant), grant_of(exp_own));
        check($sformatf("%s_ch", tag), 32'(bus.slot_ch), exp_ch);
        check($sformatf("%s_cpuok", tag), 32'(bus.cpu_ok), (exp_own == CPU) ? 1 : 0);
        @(negedge clk);
        bus.cck  = 1'b1;
        bus.hpos = 9'(s * 2 + 1);
        if (jitter) rand_inputs();
        @(posedge clk);
        #1;
        check($sformatf("%s_hold", tag), 32'(bus.owner), hold_own);
    endtask

    task automatic set_all_on();
        bus.vbl = 1'b0;  bus.vblend = 1'b0;
        bus.dmaen = 1'b1; bus.dsken = 1'b1; bus.spren = 1'b1;
        bus.copen = 1'b1; bus.blten = 1'b1; bus.bplen = 1'b1;
        bus.auden = 4'hF; bus.bltpri = 1'b0;
        bus.req_dsk = 1'b1; bus.req_aud = 4'hF; bus.req_bpl = 1'b1;
        bus.req_cop = 1'b1; bus.req_blt = 1'b1; bus.req_cpu = 1'b1;
    endtask

    initial begin
        seq_exp = '{BLT, BLT, BLT, CPU, BLT, BLT, BLT, CPU};
        _reset   = 1'b0;
        bus.cck  = 1'b1;
        bus.hpos = '0;
        set_all_on();
        #23;
        check("rst_own", 32'(bus.owner), IDLE);
        check("rst_gnt", 32'(bus.grant), 0);
        check("rst_ch", 32'(bus.slot_ch), 0);
        check("rst_cpuok", 32'(bus.cpu_ok), 0);
        @(negedge clk);
        _reset = 1'b1;

        // Refresh slots win over everything.
        for (int k = 0; k < 4; k++) begin
            run_slot(1 + 2 * k, "ref", 1'b0);
            check("ref_lit", 32'(bus.owner), REF);
        end

        // Disk slot, then disk disabled falls through to the CPU.
        bus.req_bpl = 1'b0; bus.req_cop = 1'b0; bus.req_blt = 1'b0;
        run_slot(9, "dsk", 1'b0);
        check("dsk_lit", 32'(bus.owner), DSK);
        bus.dsken = 1'b0;
        run_slot(9, "dsk_off", 1'b0);
        check("dsk_off_lit", 32'(bus.owner), CPU);
        bus.dsken = 1'b1;

        // Audio channel 2 slot.
        run_slot(19, "aud2", 1'b0);
        check("aud2_ch", 32'(bus.slot_ch), 2);

        // Sprite slot inside vertical blank, then on the last blank line.
        bus.vbl = 1'b1;
        run_slot(23, "spr_vbl", 1'b0);
        check("spr_vbl_lit", 32'(bus.owner), CPU);
        bus.vblend = 1'b1;
        run_slot(23, "spr_vblend", 1'b0);
        check("spr_vblend_lit", 32'(bus.owner), SPR);
        run_slot(29, "spr1w1", 1'b0);
        check("spr1w1_ch", 32'(bus.slot_ch), 3);
        bus.vbl = 1'b0; bus.vblend = 1'b0;

        // Free-slot priority on an even CCK.
        set_all_on();
        run_slot(60, "bpl", 1'b0);
        check("bpl_lit", 32'(bus.owner), BPL);
        bus.req_bpl = 1'b0;
        run_slot(62, "cop", 1'b0);
        check("cop_lit", 32'(bus.owner), COP);
        bus.req_bpl = 1'b1; bus.vbl = 1'b1;
        run_slot(64, "cop_vbl", 1'b0);
        check("cop_vbl_lit", 32'(bus.owner), COP);
        bus.vbl = 1'b0;

        // Blitter-nasty guard over consecutive free slots.
        bus.req_bpl = 1'b0; bus.req_cop = 1'b0; bus.req_cpu = 1'b0;
        run_slot(99, "clr", 1'b0);
        bus.req_cpu = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_slot(100 + k, "nasty", 1'b0);
            check("nasty_seq", 32'(bus.owner), seq_exp[k]);
        end
        bus.bltpri = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_slot(110 + k, "bltpri", 1'b0);
            check("bltpri_lit", 32'(bus.owner), BLT);
        end
        bus.bltpri = 1'b0;

        // Async reset during the cck==1 half of a blitter slot.
        run_slot(120, "pre_rst", 1'b0);
        run_slot(121, "pre_rst", 1'b0);
        @(negedge clk);
        bus.cck  = 1'b0;
        bus.hpos = 9'(122 * 2);
        model_slot(122);
        @(posedge clk);
        #1;
        check("rst_blt", 32'(bus.owner), BLT);
        @(negedge clk);
        bus.cck  = 1'b1;
        bus.hpos = 9'(122 * 2 + 1);
        #2;
        _reset = 1'b0;
        streak = 0;
        #1;
        check("midrst_gnt", 32'(bus.grant), 0);
        check("midrst_own", 32'(bus.owner), IDLE);
        #1;
        _reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_hold", 32'(bus.grant), 0);
        for (int k = 0; k < 4; k++) begin
            run_slot(123 + k, "restart", 1'b0);
            check("restart_seq", 32'(bus.owner), seq_exp[k]);
        end

        // Randomized slots: mostly walking the line, sometimes jumping anywhere.
        s_cur = 0;
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            if ($urandom_range(0, 7) == 0) s_cur = $urandom_range(0, 255);
            else s_cur = (s_cur >= 226) ? 0 : s_cur + 1;
            run_slot(s_cur, "rnd", 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dma_slot_scheduler.md
# dma_slot_scheduler

Chip-bus DMA slot scheduler for the ECS Agnus. It slices each video line into colour-clock (CCK) slots using the horizontal and vertical beam counters. Each slot is granted to exactly one owner: refresh, disk, audio, sprite, bitplane, copper, blitter, or CPU. The grant is registered once per CCK and drives the chip-RAM address mux and the per-channel DMA engines.

## Interface
Parameters:
- REF_FIRST, 8'h01: first refresh slot (CCK index); 4 refresh slots on odd CCKs.
- DSK_FIRST, 8'h09: first of 3 disk slots, odd CCKs.
- AUD_FIRST, 8'h0F: first of 4 audio slots, odd CCKs; channel n at AUD_FIRST+2n.
- SPR_FIRST, 8'h17: first of 16 sprite slots, odd CCKs; sprite n at SPR_FIRST+4n and +4n+2.
- BLT_NASTY_LIMIT, 3: consecutive blitter wins before the CPU is forced in.

Ports:
- clk  in  1  bus clock (2 clk per CCK).
- _reset  in  1  asynchronous, active-low reset.
- cck  in  1  CCK phase; a slot begins at the clk edge where cck==0.
- hpos  in  9  horizontal beam counter; hpos[8:1] is the CCK index 0..226.
- vbl  in  1  vertical blanking.
- vblend  in  1  last vertical-blank line.
- dmaen, dsken, spren, copen, blten, bplen  in  1 each  DMACON enables.
- auden  in  4  audio channel enables.
- bltpri  in  1  blitter-nasty bit.
- req_dsk  in  1  disk engine wants its slot.
- req_aud  in  4  audio channel wants its slot.
- req_bpl  in  1  bitplane fetch unit claims the current slot.
- req_cop  in  1  copper request.
- req_blt  in  1  blitter request.
- req_cpu  in  1  CPU chip-bus request.
- grant  out  8  one-hot {cpu,blt,cop,bpl,spr,aud,dsk,ref}, registered.
- owner  out  4  encoded owner; 0=IDLE.
- slot_ch  out  4  sub-channel: audio 0..3 or sprite 0..7 with bit 0 = data/pos word.
- cpu_ok  out  1  equals grant[7].

## Operation
- Fixed-slot decode from hpos[8:1], valid only on odd CCK indices:
  - refresh slots are always granted;
  - disk slot granted iff dmaen & dsken & req_dsk;
  - audio slot n granted iff dmaen & auden[n] & req_aud[n];
  - sprite slots granted iff dmaen & spren & (~vbl | vblend).
- A fixed slot left unused falls through to the free-slot priority below. Refresh slots never fall through.
- Free-slot priority: bitplane (dmaen & bplen & req_bpl & ~vbl) > copper (dmaen & copen & req_cop, even CCK only) > blitter (dmaen & blten & req_blt) > CPU (req_cpu) > IDLE.
- Blitter-nasty guard, 2-bit counter blt_wait:
  - Increments when the blitter wins a slot while req_cpu=1 and bltpri=0.
  - When blt_wait==BLT_NASTY_LIMIT and the slot would go to the blitter, the CPU wins instead and blt_wait clears.
  - blt_wait clears on any CPU grant, when req_cpu=0, or when bltpri=1.
  - It holds on slots won by higher-priority owners.
- CCK indices 227..255 (hpos[8:1] > 226, possible only after a VHPOSW write) are treated as free slots.

## Timing
- Decision is taken at the clk edge where cck==0, from the current hpos and request inputs.
- grant, owner and slot_ch update on that edge and hold for exactly 2 clk (one CCK).
- Latency: the grant for CCK k is visible 1 clk after hpos[8:1] becomes k.
- Requests must be stable at the deciding edge; changes in the cck==1 clk are ignored until the next slot.
- Line wrap (hpos[8:1] 226→0) needs no special handling; CCK 0 is a free slot.
- Reset values: grant=0, owner=IDLE, slot_ch=0, cpu_ok=0, blt_wait=0. A reset mid-slot drops the grant immediately (async). The first decision after release occurs at the next cck==0 edge.
- dmaen deasserted mid-slot takes effect at the next slot only.

## Structure
- Shared package dma_pkg:
  - owner encoding constants: IDLE, REF, DSK, AUD, SPR, BPL, COP, BLT, CPU;
  - grant bit indices;
  - the default slot-position constants.
- Sub-module dma_slot_decode: purely combinational hpos[8:1] → {fixed owner, slot_ch}. It is reused by the bus-cycle debug monitor.
- The top level holds the priority resolver, blt_wait counter and output registers.

## Test plan
- CCKs $01,$03,$05,$07 with all requests high → grant=REF for each; CCK $09 with req_dsk=1, dsken=1 → DSK, with dsken=0 → falls through to CPU.
- vpos in vbl (not vblend), spren=1, CCK $17 → not SPR, goes to free priority; same with vblend=1 → SPR, slot_ch=0.
- Even CCK with req_bpl, req_cop, req_blt, req_cpu all high, vbl=0 → BPL; drop req_bpl → COP; with vbl=1 → COP even with req_bpl high.
- bltpri=0, req_blt and req_cpu held high over 8 consecutive free CCKs → sequence BLT,BLT,BLT,CPU,BLT,BLT,BLT,CPU; bltpri=1 → all BLT.
- Assert _reset=0 during the cck==1 phase of a BLT slot → grant=0 within the same clk; release → next grant on the following cck==0 edge, blt_wait restarted.
